// File: rtl/pipe_hazard_pkg.sv
// Shared types and helpers for the pipeline hazard / forwarding controller.
// Struct fields are sized for the largest supported configuration; modules zero-extend.
package pipe_hazard_pkg;

  localparam int unsigned REGW_MAX = 8;
  localparam int unsigned SW_MAX   = 4;
  localparam int unsigned FWD_RF   = 0;

  typedef struct packed {
    logic                valid;
    logic [REGW_MAX-1:0] rd;
    logic                we;
    logic [SW_MAX-1:0]   avail;
    logic                is_long;
  } stage_entry_t;

  // Stage k forwards through select value k+1; 0 is the register file.
  function automatic logic [SW_MAX-1:0] stage_sel(input int k);
    return SW_MAX'(k + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_match.sv
// Youngest-stage match search for one source operand.
// Returns hit, a not-yet-available stall, and the forward select.
module hazard_match
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned NSTAGE = 3,
  parameter int unsigned REGW   = 5,
  parameter int unsigned SW     = 2
) (
  input  stage_entry_t    stages [NSTAGE],
  input  logic [REGW-1:0] src,
  input  logic            used,
  output logic            hit,
  output logic            stall,
  output logic [SW-1:0]   sel
);

  always_comb begin
    hit   = 1'b0;
    stall = 1'b0;
    sel   = SW'(FWD_RF);
    if (used && (src != '0)) begin
      // Walk oldest to youngest so the youngest match wins.
      for (int k = int'(NSTAGE) - 1; k >= 0; k--) begin
        if (stages[k].valid && stages[k].we && (stages[k].rd == REGW_MAX'(src))) begin
          hit = 1'b1;
          if (SW_MAX'(k) < stages[k].avail) begin
            stall = 1'b1;
            sel   = SW'(FWD_RF);
          end else begin
            stall = 1'b0;
            sel   = SW'(stage_sel(k));
          end
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Issue-stage hazard detection, operand forwarding and long-op scoreboard
// for an in-order pipeline with NSTAGE tracked post-issue stages.
module pipe_hazard_unit
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned NSTAGE = 3,
  parameter int unsigned NREG   = 32,
  parameter int unsigned REGW   = $clog2(NREG),
  parameter int unsigned SW     = $clog2(NSTAGE + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic [REGW-1:0]           issue_rs,
  input  logic [REGW-1:0]           issue_rt,
  input  logic                      issue_rs_used,
  input  logic                      issue_rt_used,
  input  logic [REGW-1:0]           issue_rd,
  input  logic                      issue_we,
  input  logic [SW-1:0]             issue_avail,
  input  logic                      issue_long,
  input  logic                      lng_done,
  input  logic [REGW-1:0]           lng_rd,
  input  logic                      hold,
  input  logic                      flush_valid,
  input  logic [SW-1:0]             flush_stage,
  output logic                      issue_fire,
  output logic                      issue_stall,
  output logic [SW-1:0]             fwd_rs_sel,
  output logic [SW-1:0]             fwd_rt_sel,
  output logic                      lng_kill,
  output logic [$clog2(NREG+1)-1:0] busy_cnt
);

  localparam int unsigned CW = $clog2(NREG + 1);

  stage_entry_t    stage_q [NSTAGE];
  stage_entry_t    stage_d [NSTAGE];
  stage_entry_t    surv    [NSTAGE];
  stage_entry_t    issue_entry;
  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] set_vec, clr_vec;
  logic [CW-1:0]   cnt_q, cnt_d, n_clr;

  logic rs_hit, rs_stall, rt_hit, rt_stall;
  logic rs_haz, rt_haz, waw, hazard;

  hazard_match #(
    .NSTAGE(NSTAGE),
    .REGW  (REGW),
    .SW    (SW)
  ) u_match_rs (
    .stages(stage_q),
    .src   (issue_rs),
    .used  (issue_rs_used),
    .hit   (rs_hit),
    .stall (rs_stall),
    .sel   (fwd_rs_sel)
  );

  hazard_match #(
    .NSTAGE(NSTAGE),
    .REGW  (REGW),
    .SW    (SW)
  ) u_match_rt (
    .stages(stage_q),
    .src   (issue_rt),
    .used  (issue_rt_used),
    .hit   (rt_hit),
    .stall (rt_stall),
    .sel   (fwd_rt_sel)
  );

  // A scoreboard hit only matters when no in-flight stage supplies the value.
  always_comb begin
    rs_haz = rs_stall |
             (~rs_hit & issue_rs_used & (issue_rs != '0) & busy_q[issue_rs]);
    rt_haz = rt_stall |
             (~rt_hit & issue_rt_used & (issue_rt != '0) & busy_q[issue_rt]);
    waw    = (issue_we | issue_long) & busy_q[issue_rd];
    hazard = rs_haz | rt_haz | waw;
    issue_stall = issue_valid & (hazard | hold);
    issue_fire  = issue_valid & ~issue_stall & ~flush_valid;
  end

  always_comb begin
    issue_entry.valid   = 1'b1;
    issue_entry.rd      = REGW_MAX'(issue_rd);
    issue_entry.we      = issue_we & ~issue_long;
    issue_entry.avail   = SW_MAX'(issue_avail);
    issue_entry.is_long = issue_long;

    lng_kill = 1'b0;
    clr_vec  = '0;
    for (int k = 0; k < int'(NSTAGE); k++) begin
      surv[k] = stage_q[k];
      if (flush_valid && (SW'(k) <= flush_stage)) begin
        surv[k].valid = 1'b0;
        if (stage_q[k].valid && stage_q[k].is_long) begin
          lng_kill = 1'b1;
          clr_vec[stage_q[k].rd[REGW-1:0]] = 1'b1;
        end
      end
    end

    // Flush still applies in place while the pipeline is held.
    if (hold) begin
      stage_d = surv;
    end else begin
      stage_d[0] = issue_fire ? issue_entry : '0;
      for (int k = 1; k < int'(NSTAGE); k++) begin
        stage_d[k] = surv[k-1];
      end
    end

    if (lng_done) begin
      clr_vec[lng_rd] = 1'b1;
    end
    clr_vec = clr_vec & busy_q;

    set_vec = '0;
    if (issue_fire && issue_long && (issue_rd != '0)) begin
      set_vec[issue_rd] = 1'b1;
    end

    busy_d = (busy_q & ~clr_vec) | set_vec;

    n_clr = '0;
    for (int r = 0; r < int'(NREG); r++) begin
      n_clr = n_clr + CW'(clr_vec[r]);
    end
    cnt_d = cnt_q + CW'(|set_vec) - n_clr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(NSTAGE); k++) begin
        stage_q[k] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int k = 0; k < int'(NSTAGE); k++) begin
        stage_q[k] <= stage_d[k];
      end
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

endmodule
